// File: rtl/key_debounce.sv
// Debounced mechanical key: 2-flop synchronizer, one-hot filter FSM, press/release pulses.
// Optional long-press detector is built when the LONG_PRESS_EN macro is defined.
module key_debounce #(
    parameter int unsigned CNT_MAX  = 1000000,
    parameter int unsigned LONG_MAX = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    function automatic int unsigned f_clog2(input int unsigned value);
        int unsigned width;
        int unsigned rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

    localparam int unsigned      CNT_W   = f_clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    typedef enum logic [3:0] {
        IDLE         = 4'b0001,
        PRESS_FILT   = 4'b0010,
        HELD         = 4'b0100,
        RELEASE_FILT = 4'b1000
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_key_s;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;

    assign w_key_s = r_sync2;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep the two flops a true pipeline.
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            key_level   <= w_level_nxt;
            key_press   <= w_press_nxt;
            key_release <= w_release_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = key_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_key_s) begin
                    w_state_nxt = PRESS_FILT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_FILT: begin
                if (w_key_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TOP) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (w_key_s) begin
                    w_state_nxt = RELEASE_FILT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_FILT: begin
                if (!w_key_s) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TOP) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned       LONG_W   = f_clog2(LONG_MAX + 1);
    localparam logic [LONG_W-1:0] LONG_TOP = LONG_W'(LONG_MAX);

    logic [LONG_W-1:0] r_long_cnt;
    logic              w_long_run;

    // Leaving for IDLE clears the counter, so a release edge can never also carry key_long.
    assign w_long_run = ((r_state == HELD) || (r_state == RELEASE_FILT)) && (w_state_nxt != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long_cnt <= '0;
            key_long   <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (!w_long_run) begin
                r_long_cnt <= '0;
            end else if (r_long_cnt != LONG_TOP) begin
                r_long_cnt <= r_long_cnt + 1'b1;
                key_long   <= (r_long_cnt == LONG_TOP - 1'b1);
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (CNT_MAX=8, LONG_MAX=40): stimulus queues expected
// pulses with their cycle, a negedge monitor pops and compares each pulse it sees.
module tb_key_debounce;

    localparam int LAT      = 11;  // CNT_MAX + 3 with CNT_MAX = 8
    localparam int LONG_LAT = 40;  // LONG_MAX

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_e;
    typedef struct {
        ev_e kind;
        int  cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic key_n;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    exp_t exp_q[$];
    int   cyc;
    int   base;
    int   n_total;
    int   n_pass;
    int   m_n;
    ev_e  m_kind;
    exp_t m_exp;

    key_debounce #(
        .CNT_MAX (8),
        .LONG_MAX(40)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic expect_ev(input ev_e kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic level, input int n);
        key_n = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   int'(key_level),   0);
        check({tag, "_press"},   int'(key_press),   0);
        check({tag, "_release"}, int'(key_release), 0);
        check({tag, "_long"},    int'(key_long),    0);
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        m_n = int'(key_press) + int'(key_release) + int'(key_long);
        if (m_n > 1) check("pulse_exclusive", m_n, 1);
        if (m_n >= 1) begin
            m_kind = key_press ? EV_PRESS : (key_release ? EV_RELEASE : EV_LONG);
            if (exp_q.size() == 0) begin
                check("spurious_pulse_kind", int'(m_kind), -1);
            end else begin
                m_exp = exp_q.pop_front();
                check("event_kind",  int'(m_kind),    int'(m_exp.kind));
                check("event_cycle", cyc,             m_exp.cyc);
                check("event_level", int'(key_level), (m_exp.kind == EV_RELEASE) ? 0 : 1);
            end
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        key_n   = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        hold(1'b1, 3);

        // Clean press then clean release
        base = cyc; expect_ev(EV_PRESS, base + LAT);
        hold(1'b0, 30);
        check("clean_press_level", int'(key_level), 1);
        base = cyc; expect_ev(EV_RELEASE, base + LAT);
        hold(1'b1, 20);
        check("clean_release_level", int'(key_level), 0);

        // Bounce rejection: no run reaches CNT_MAX
        hold(1'b0, 5);
        hold(1'b1, 3);
        hold(1'b0, 5);
        hold(1'b1, 20);
        check("bounce_level", int'(key_level), 0);

        // Press bounce then settle
        hold(1'b0, 4);
        hold(1'b1, 2);
        base = cyc; expect_ev(EV_PRESS, base + LAT);
        hold(1'b0, 25);
        check("settle_press_level", int'(key_level), 1);

        // Release with a low glitch that restarts filtering
        hold(1'b1, 5);
        hold(1'b0, 3);
        check("glitch_still_held", int'(key_level), 1);
        base = cyc; expect_ev(EV_RELEASE, base + LAT);
        hold(1'b1, 20);
        check("glitch_release_level", int'(key_level), 0);

        // Long hold
        base = cyc; expect_ev(EV_PRESS, base + LAT);
`ifdef LONG_PRESS_EN
        expect_ev(EV_LONG, base + LAT + LONG_LAT);
`endif
        hold(1'b0, 100);
        base = cyc; expect_ev(EV_RELEASE, base + LAT);
        hold(1'b1, 20);

        // Reset mid-HELD while the key stays down
        base = cyc; expect_ev(EV_PRESS, base + LAT);
        hold(1'b0, 16);
        check("pre_reset_level", int'(key_level), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc; expect_ev(EV_PRESS, base + LAT);
        hold(1'b0, 20);
        check("post_reset_level", int'(key_level), 1);
        base = cyc; expect_ev(EV_RELEASE, base + LAT);
        hold(1'b1, 20);

        repeat (5) @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 1000000, giving the consecutive synchronized clocks of stable level needed to accept a change (20 ms at 50 MHz); legal range is CNT_MAX >= 1.
REQ-002 The block SHALL have parameter LONG_MAX, default 100000000, giving the clocks in HELD before a long-press is flagged; it is used only under LONG_PRESS_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port key_n, input, 1 bit: raw mechanical key, asynchronous to clk, low = pressed.
REQ-006 The block SHALL have port key_level, output, 1 bit: debounced key level, 1 = pressed.
REQ-007 The block SHALL have port key_press, output, 1 bit: one-clock pulse on each accepted press; it is the trigger source for the downstream single-pulse generator.
REQ-008 The block SHALL have port key_release, output, 1 bit: one-clock pulse on each accepted release.
REQ-009 The block SHALL have port key_long, output, 1 bit: one-clock long-press pulse; the port is always present.

Function
REQ-010 key_n SHALL pass through a two-flop synchronizer; the second flop output key_s is the only value the FSM observes.
REQ-011 The FSM SHALL have one-hot states IDLE, PRESS_FILT, HELD and RELEASE_FILT, with a single shared counter cnt.
REQ-012 cnt width SHALL be clog2(CNT_MAX+1), computed internally by a constant function.
REQ-013 In IDLE with key_s=0, the FSM SHALL go to PRESS_FILT and set cnt to 1.
REQ-014 In IDLE with key_s=1, the FSM SHALL remain in IDLE.
REQ-015 In PRESS_FILT with key_s=1 (bounce), the FSM SHALL return to IDLE and set cnt to 0, with no output change.
REQ-016 In PRESS_FILT with key_s=0 and cnt<CNT_MAX, the FSM SHALL increment cnt.
REQ-017 In PRESS_FILT with key_s=0 and cnt==CNT_MAX, the FSM SHALL go to HELD and register key_level=1 and key_press=1 on that same edge.
REQ-018 In HELD with key_s=1, the FSM SHALL go to RELEASE_FILT and set cnt to 1; release filtering is symmetric to press filtering.
REQ-019 In RELEASE_FILT with key_s=0, the FSM SHALL return to HELD and set cnt to 0.
REQ-020 In RELEASE_FILT with key_s=1 and cnt==CNT_MAX, the FSM SHALL go to IDLE and register key_level=0 and key_release=1.
REQ-021 key_press, key_release and key_long SHALL each be high for exactly one clock; at most one of them SHALL be high in any cycle.
REQ-022 With key_n held low from the edge that first samples it low, key_press SHALL be high immediately after rising edge number CNT_MAX+3; key_release latency SHALL be the same.
REQ-023 Any run of key_s shorter than CNT_MAX consecutive clocks SHALL produce no output change.
REQ-024 cnt SHALL never exceed CNT_MAX and SHALL never wrap.
REQ-025 Unreachable or illegal state encodings SHALL recover to IDLE on the next clock, with outputs set to 0.

Reset
REQ-026 On rst_n low, the block SHALL immediately and asynchronously force: state=IDLE, cnt=0, both synchronizer flops=1 (released), key_level=0, key_press=0, key_release=0, key_long=0, long counter=0.
REQ-027 Reset asserted mid-filter or mid-HELD SHALL discard all progress; after reset, a key still held SHALL be treated as a new press and SHALL yield key_press after CNT_MAX+3 clocks.

Configuration
REQ-028 Macro LONG_PRESS_EN, when defined, SHALL add a long counter that runs while in HELD or RELEASE_FILT, clears on entering IDLE, and saturates.
REQ-029 With LONG_PRESS_EN defined, key_long SHALL pulse once when the long counter reaches LONG_MAX, and at most once per accepted press.
REQ-030 With LONG_PRESS_EN undefined, the long counter SHALL be absent and key_long SHALL be tied to 0.

Verification (CNT_MAX=8, LONG_MAX=40)
REQ-031 Clean press: key_n 1->0 held 30 clocks -> key_press pulses once 11 clocks after the first low sample, key_level=1 on that same clock.
REQ-032 Bounce rejection: key_n low 5 clocks, high 3, low 5, then high -> key_level, key_press and key_release stay 0 throughout.
REQ-033 Press bounce then settle: key_n low 4, high 2, then low held -> key_press fires 11 clocks after the start of the final low run, exactly one pulse.
REQ-034 Release: from HELD, key_n 0->1 held -> key_release pulses 11 clocks later, key_level=0; a 3-clock low glitch during release filtering restarts the 11-clock count.
REQ-035 Reset mid-HELD: rst_n low for 2 clocks while key_n=0 -> all outputs 0 immediately; after rst_n rises, key_press fires again 11 clocks later.
REQ-036 LONG_PRESS_EN defined, key_n held low 100 clocks -> key_long pulses exactly once, 40 clocks after key_press; with the macro undefined -> key_long stays 0.
